// File: rtl/sr_wb_shift_engine.sv
// sr_wb_shift_engine: Wishbone-classic slave that serialises a word
// on shift-clock/latch pins and captures a serial return word.
module sr_wb_shift_engine #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          WIDTH     = 32,
  parameter int          DIV_W     = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        sr_clk_o,
  output logic        sr_dat_o,
  input  logic        sr_dat_i,
  output logic        sr_latch_o,
  output logic [2:0]  sr_oeb_o,
  output logic        irq_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT_LO,
    SHIFT_HI,
    LATCH
  } state_t;

  state_t state;
  state_t state_nx;

  logic             ctrl_msb;
  logic             ctrl_oe;
  logic             ctrl_irq_en;
  logic [DIV_W-1:0] ctrl_div;
  logic [WIDTH-1:0] tx;
  logic [WIDTH-1:0] rx;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] sh_nx;
  logic [WIDTH-1:0] cap;
  logic             done;
  logic             ovr;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt;
  logic             msb_q;
  logic [CW-1:0]    bitcnt;
  logic             clk_nx;
  logic             latch_nx;

  logic        hit;
  logic        acc;
  logic        wr;
  logic        rd;
  logic [1:0]  off;
  logic        wr_ctrl;
  logic        wr_tx;
  logic        wr_stat;
  logic        busy;
  logic        start_req;
  logic        start_go;
  logic        ovr_set;
  logic        done_set;
  logic        w1c;
  logic        tick;
  logic        last_bit;
  logic [31:0] tx_m;
  logic [31:0] rd_mux;
  logic        unused_ok;

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] d,
    input logic [3:0]  s
  );
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    end
    return r;
  endfunction

  assign hit = wbs_cyc_i & wbs_stb_i &
               (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  // Ack is a one-cycle pulse; the low cycle after it blocks back-to-back.
  assign acc = hit & ~wbs_ack_o;
  assign wr  = acc & wbs_we_i;
  assign rd  = acc & ~wbs_we_i;
  assign off = wbs_adr_i[3:2];

  assign wr_ctrl = wr & (off == 2'd0);
  assign wr_tx   = wr & (off == 2'd1);
  assign wr_stat = wr & (off == 2'd3);

  assign busy      = (state != IDLE);
  assign start_req = wr_ctrl & wbs_sel_i[0] & wbs_dat_i[0];
  assign start_go  = start_req & ~busy;
  assign ovr_set   = (start_req | wr_tx) & busy;
  assign tick      = (cnt == div_q);
  assign last_bit  = (bitcnt == CW'(1));
  assign done_set  = (state == LATCH) & tick;
  assign w1c       = wr_stat & wbs_sel_i[0];

  assign tx_m  = merge(32'(tx), wbs_dat_i, wbs_sel_i);
  assign sh_nx = msb_q ? (sh << 1) : (sh >> 1);

  assign sr_oeb_o  = {3{~ctrl_oe}};
  assign irq_o     = done & ctrl_irq_en;
  assign unused_ok = &{1'b0, wbs_adr_i[1:0]};

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) state <= IDLE;
    else           state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (start_go) state_nx = LOAD;
      LOAD:     state_nx = SHIFT_LO;
      SHIFT_LO: if (tick) state_nx = SHIFT_HI;
      SHIFT_HI: if (tick) state_nx = last_bit ? LATCH : SHIFT_LO;
      LATCH:    if (tick) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Pin levels are decoded from the next state and registered.
  always_comb begin
    clk_nx   = 1'b0;
    latch_nx = 1'b0;
    unique case (1'b1)
      (state_nx == SHIFT_HI): clk_nx   = 1'b1;
      (state_nx == LATCH):    latch_nx = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      cnt        <= '0;
      sr_clk_o   <= 1'b0;
      sr_latch_o <= 1'b0;
      sr_dat_o   <= 1'b0;
      sh         <= '0;
      cap        <= '0;
      rx         <= '0;
      bitcnt     <= '0;
      div_q      <= '0;
      msb_q      <= 1'b0;
    end else begin
      if (state_nx != state || state == IDLE) cnt <= '0;
      else                                   cnt <= cnt + DIV_W'(1);
      sr_clk_o   <= clk_nx;
      sr_latch_o <= latch_nx;
      if (state == LOAD) begin
        sh       <= tx;
        bitcnt   <= CW'(WIDTH);
        div_q    <= ctrl_div;
        msb_q    <= ctrl_msb;
        sr_dat_o <= ctrl_msb ? tx[WIDTH-1] : tx[0];
      end
      if (state == SHIFT_HI && cnt == '0) begin
        cap <= msb_q ? {cap[WIDTH-2:0], sr_dat_i}
                     : {sr_dat_i, cap[WIDTH-1:1]};
      end
      if (state == SHIFT_HI && tick) begin
        bitcnt <= bitcnt - CW'(1);
        if (!last_bit) begin
          sh       <= sh_nx;
          sr_dat_o <= msb_q ? sh_nx[WIDTH-1] : sh_nx[0];
        end
      end
      if (done_set) rx <= cap;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      ctrl_msb    <= 1'b0;
      ctrl_oe     <= 1'b0;
      ctrl_irq_en <= 1'b0;
      ctrl_div    <= '0;
      tx          <= '0;
      done        <= 1'b0;
      ovr         <= 1'b0;
    end else begin
      if (wr_ctrl && wbs_sel_i[0]) begin
        {ctrl_irq_en, ctrl_oe, ctrl_msb} <= wbs_dat_i[3:1];
      end
      if (wr_ctrl && wbs_sel_i[1]) ctrl_div <= wbs_dat_i[8 +: DIV_W];
      if (wr_tx && !busy) tx <= tx_m[WIDTH-1:0];
      if (done_set)           done <= 1'b1;
      else if (start_go)      done <= 1'b0;
      else if (w1c && wbs_dat_i[1]) done <= 1'b0;
      if (ovr_set)                  ovr <= 1'b1;
      else if (w1c && wbs_dat_i[2]) ovr <= 1'b0;
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      (off == 2'd0): begin
        rd_mux[3:1]         = {ctrl_irq_en, ctrl_oe, ctrl_msb};
        rd_mux[8 +: DIV_W]  = ctrl_div;
      end
      (off == 2'd1): rd_mux[WIDTH-1:0] = tx;
      (off == 2'd2): rd_mux[WIDTH-1:0] = rx;
      (off == 2'd3): rd_mux[2:0] = {ovr, done, busy};
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= acc;
      wbs_dat_o <= rd ? rd_mux : '0;
    end
  end

endmodule
